tohost_monitor: RTL

Host-side consumer of the `tohost_csr` register driven by the CSR write logic. Each cycle it samples `tohost_csr`, queues every nonzero word into a small FIFO drained by the host over a valid/ready handshake, and decodes the riscv-tests termination convention into pass/fail status. A cycle counter with a timeout flags programs that never terminate. It sits beside the core in the 6-stage pipeline test harness, reached only through `tohost_csr`.

---
 rtl/tohost_monitor.sv | 99 +++++++++
 1 files changed

// File: rtl/tohost_monitor.sv
// Host-side monitor for the tohost CSR: queues nonzero words for the host,
// decodes riscv-tests pass/fail termination and flags runaway programs.
module tohost_monitor #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tohost_csr,
  output logic [31:0] host_data,
  output logic        host_valid,
  input  logic        host_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] test_fail_id,
  output logic        timeout,
  output logic        overflow,
  output logic [31:0] cycle_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic empty;
  logic full;
  logic pop;
  logic capture;
  logic term;
  logic push;
  logic hit_limit;

  // Wrap-bit pointers: equal means empty, only wrap bits differing means full.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop       = !empty && host_ready;
  assign capture   = (state == ST_RUN) && (tohost_csr != 32'd0);
  assign term      = capture && tohost_csr[0];
  assign push      = capture && (!full || pop);
  assign hit_limit = ((33'(cycle_count) + 33'd1) == 33'(TIMEOUT_CYCLES));

  assign host_valid = !empty;
  assign host_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wptr         <= '0;
      rptr         <= '0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_fail_id <= '0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
      cycle_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= tohost_csr;
        wptr              <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (capture && full && !pop) begin
        overflow <= 1'b1;
      end

      // A terminating word updates status even when the FIFO drops it.
      if (term) begin
        test_done    <= 1'b1;
        test_pass    <= (tohost_csr == 32'd1);
        test_fail_id <= (tohost_csr == 32'd1) ? 31'd0 : tohost_csr[31:1];
        state        <= ST_DONE;
      end

      if (state == ST_RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (!term && hit_limit) begin
          timeout <= 1'b1;
          state   <= ST_TIMEOUT;
        end
      end
    end
  end

endmodule
